fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Program-counter and control-flow stage directly upstream of the 1024-entry instruction memory; drives its 10-bit address every cycle.
- Applies taken-branch, relative-skip, subroutine call/return and halt requests from decode, which maps them from bnzr, jizr, jtsr, rfsr and func done.
- Holds a 16-entry subroutine target table and a small return-address stack.

Parameters:
START_PC, 0, PC value loaded on start.
RAS_DEPTH, 4, return-address stack depth (1..8).

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  begin execution from START_PC (pulse)
stall  in  1  hold PC and all state this cycle
rel_take  in  1  relative skip taken (jizr)
rel_off  in  3  skip distance for rel_take
abs_take  in  1  absolute branch taken (bnzr)
abs_tgt  in  10  absolute branch target
call  in  1  subroutine call (jtsr)
call_idx  in  4  table index for call
ret  in  1  subroutine return (rfsr)
halt  in  1  stop execution (func done)
tbl_we  in  1  write subroutine table entry
tbl_idx  in  4  table write index
tbl_addr  in  10  table write data
pc  out  10  instruction memory address
run  out  1  high while in RUN
done  out  1  high while in HALT
ras_err  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset when reset_n=0 at a clock edge: pc=0, state IDLE, run=0, done=0, ras_err=0, stack pointer=0, all table entries=0. Reset mid-run aborts immediately, with no drain.
- States: IDLE -> RUN on start. RUN -> HALT on halt. HALT -> RUN on start. IDLE and HALT ignore every control input except start and tbl_we.
- On start: pc=START_PC, stack pointer=0, ras_err cleared.
- In RUN with stall=0, next pc is selected by strict priority:
  - halt: pc holds.
  - ret: pc=top of stack, then pop.
  - call: push pc+1, pc=table[call_idx].
  - abs_take: pc=abs_tgt.
  - rel_take: pc=pc+1+rel_off.
  - otherwise: pc=pc+1.
- Lower-priority requests in the same cycle are discarded.
- stall=1 in RUN: pc, stack and state hold. Table writes still occur.
- All pc arithmetic is modulo 1024: 1023+1=0, and 1022+1+3 wraps to 2.
- Call with stack full: jump is taken, push is dropped, ras_err=1.
- Ret with stack empty: pc=pc+1, ras_err=1.
- ras_err stays set until reset or start.
- Table write takes effect next cycle. A call in the same cycle reads the old entry.
- No combinational path from any input to pc. Latency is one clock from request to new pc; the instruction memory read is combinational on pc.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs cyc_cnt[15:0] (increments each unstalled RUN cycle) and flow_cnt[15:0] (increments on each taken ret, call, abs_take or rel_take). Both counters saturate at 16'hFFFF and clear on reset and on start.
- Undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Sequential fetch and wrap: reset, then start with START_PC=1021 and 4 idle cycles -> pc reads 1021, 1022, 1023, 0, 1; run=1, done=0.
- Relative skip with concurrent branch: pc=30 with rel_take=1, rel_off=1 -> pc=32. Next cycle rel_take=1 and abs_take=1 with abs_tgt=15 -> pc=15.
- Nested calls and returns: tbl[1]=62, tbl[2]=72. At pc=19 call idx 1 -> pc=62. At 62 call idx 2 -> pc=72. Then ret -> pc=63, ret -> pc=20; ras_err=0.
- RAS limits: RAS_DEPTH=4. Five nested calls -> ras_err=1 and the fifth jump still taken. After reset, ret at pc=5 with empty stack -> pc=6, ras_err=1.
- Stall and halt: stall at pc=40 for 3 cycles -> pc stays 40. Halt with call asserted -> pc holds, done=1, run=0. Further calls are ignored; start -> pc=START_PC.
- Reset mid-run: reset_n low at pc=100 with 2 entries on the stack -> next cycle pc=0, IDLE, stack empty, table zeroed. With FETCH_PERF_EN defined, cyc_cnt and flow_cnt read 0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   Program counter and control-flow stage in front of a 1024-entry
//   instruction memory. Applies halt / return / call / absolute branch /
//   relative skip requests from decode. A 16-entry table supplies the call
//   targets and a small return-address stack holds the return addresses.
//
//   Optional feature: define FETCH_PERF_EN to add the saturating
//   cyc_cnt / flow_cnt performance counters.
//
// Parameters
//   START_PC   PC value loaded on start
//   RAS_DEPTH  return-address stack depth (1..8)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset_n    synchronous active-low reset
//   start      begin execution from START_PC (pulse, IDLE/HALT only)
//   stall      hold PC, stack and state for this RUN cycle
//   rel_take   relative skip taken, rel_off = skip distance
//   abs_take   absolute branch taken, abs_tgt = target
//   call       subroutine call through table[call_idx]
//   ret        subroutine return
//   halt       stop execution
//   tbl_we     write table[tbl_idx] = tbl_addr (visible next cycle)
//   pc         instruction memory address (registered)
//   run        high while in RUN
//   done       high while in HALT
//   ras_err    sticky stack overflow/underflow flag
//   cyc_cnt    (FETCH_PERF_EN) unstalled RUN cycles, saturating
//   flow_cnt   (FETCH_PERF_EN) taken ret/call/abs/rel, saturating
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int unsigned START_PC  = 0,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stall,
    input  logic        rel_take,
    input  logic [2:0]  rel_off,
    input  logic        abs_take,
    input  logic [9:0]  abs_tgt,
    input  logic        call,
    input  logic [3:0]  call_idx,
    input  logic        ret,
    input  logic        halt,
    input  logic        tbl_we,
    input  logic [3:0]  tbl_idx,
    input  logic [9:0]  tbl_addr,
    output logic [9:0]  pc,
    output logic        run,
    output logic        done,
    output logic        ras_err
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] cyc_cnt,
    output logic [15:0] flow_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Stack storage is sized for the maximum depth so a 3-bit index always
    // fits; only the first RAS_DEPTH entries are ever written.
    localparam logic [3:0] SP_FULL = 4'(RAS_DEPTH);

    state_t      state_q, state_d;
    logic [9:0]  pc_q, pc_d;
    logic        run_q, run_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [3:0]  sp_q, sp_d;
    logic [9:0]  stack_q [8];
    logic [9:0]  stack_d [8];
    logic [9:0]  tbl_q [16];
    logic [9:0]  tbl_d [16];
    logic        start_ev;
    logic        flow_ev;
    logic        cyc_ev;

    logic [9:0]  pc_inc;
    logic [2:0]  top_idx;
    logic [2:0]  push_idx;

    assign pc_inc   = pc_q + 10'd1;
    assign top_idx  = 3'(sp_q - 4'd1);
    assign push_idx = sp_q[2:0];

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        err_d    = err_q;
        sp_d     = sp_q;
        stack_d  = stack_q;
        tbl_d    = tbl_q;
        start_ev = 1'b0;
        flow_ev  = 1'b0;
        cyc_ev   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d  = ST_RUN;
                    pc_d     = 10'(START_PC);
                    sp_d     = 4'd0;
                    err_d    = 1'b0;
                    start_ev = 1'b1;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    cyc_ev = 1'b1;
                    // Strict priority; lower requests in the same cycle are dropped.
                    if (halt) begin
                        state_d = ST_HALT;
                    end else if (ret) begin
                        flow_ev = 1'b1;
                        if (sp_q == 4'd0) begin
                            pc_d  = pc_inc;
                            err_d = 1'b1;
                        end else begin
                            pc_d = stack_q[top_idx];
                            sp_d = sp_q - 4'd1;
                        end
                    end else if (call) begin
                        flow_ev = 1'b1;
                        // Reads the registered table, so a same-cycle write is not seen.
                        pc_d    = tbl_q[call_idx];
                        if (sp_q == SP_FULL) begin
                            err_d = 1'b1;
                        end else begin
                            stack_d[push_idx] = pc_inc;
                            sp_d              = sp_q + 4'd1;
                        end
                    end else if (abs_take) begin
                        flow_ev = 1'b1;
                        pc_d    = abs_tgt;
                    end else if (rel_take) begin
                        flow_ev = 1'b1;
                        pc_d    = pc_inc + 10'(rel_off);
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tbl_we) begin
            tbl_d[tbl_idx] = tbl_addr;
        end

        run_d  = (state_d == ST_RUN);
        done_d = (state_d == ST_HALT);
    end

    // NOTE: stack contents are deliberately left out of reset; the stack
    // pointer alone defines which entries are valid. The call table, by
    // contrast, must read as zero after reset.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= 10'd0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sp_q    <= 4'd0;
            tbl_q   <= '{default: 10'd0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sp_q    <= sp_d;
            tbl_q   <= tbl_d;
        end
    end

    assign pc      = pc_q;
    assign run     = run_q;
    assign done    = done_q;
    assign ras_err = err_q;

`ifdef FETCH_PERF_EN
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] flow_q, flow_d;

    always_comb begin
        cyc_d  = cyc_q;
        flow_d = flow_q;
        if (start_ev) begin
            cyc_d  = 16'd0;
            flow_d = 16'd0;
        end else begin
            if (cyc_ev && cyc_q != 16'hFFFF) begin
                cyc_d = cyc_q + 16'd1;
            end
            if (flow_ev && flow_q != 16'hFFFF) begin
                flow_d = flow_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cyc_q  <= 16'd0;
            flow_q <= 16'd0;
        end else begin
            cyc_q  <= cyc_d;
            flow_q <= flow_d;
        end
    end

    assign cyc_cnt  = cyc_q;
    assign flow_cnt = flow_q;
`else
    logic unused_perf;
    assign unused_perf = ^{start_ev, flow_ev, cyc_ev};
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit
//   Directed walk through the main scenarios followed by a randomized run.
//   Each cycle's stimulus is applied to a reference model (queue-based stack,
//   plain array table); the expected outputs go into a scoreboard queue that
//   a separate monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;

    localparam int START_PC  = 1021;
    localparam int RAS_DEPTH = 4;

    typedef struct packed {
        bit       reset_n;
        bit       start;
        bit       stall;
        bit       rel_take;
        bit [2:0] rel_off;
        bit       abs_take;
        bit [9:0] abs_tgt;
        bit       call;
        bit [3:0] call_idx;
        bit       ret;
        bit       halt;
        bit       tbl_we;
        bit [3:0] tbl_idx;
        bit [9:0] tbl_addr;
    } stim_t;

    typedef struct {
        int pc;
        int run;
        int done;
        int err;
        int cyc;
        int flow;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n, start, stall, rel_take, abs_take, call, ret, halt, tbl_we;
    logic [2:0]  rel_off;
    logic [9:0]  abs_tgt, tbl_addr;
    logic [3:0]  call_idx, tbl_idx;
    logic [9:0]  pc;
    logic        run, done, ras_err;
`ifdef FETCH_PERF_EN
    logic [15:0] cyc_cnt, flow_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    exp_t sb_q[$];

    // Reference model state
    int m_pc, m_st, m_err, m_cyc, m_flow;   // m_st: 0 idle, 1 run, 2 halt
    int m_stk[$];
    int m_tbl[16];

    fetch_pc_unit #(.START_PC(START_PC), .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stall    (stall),
        .rel_take (rel_take),
        .rel_off  (rel_off),
        .abs_take (abs_take),
        .abs_tgt  (abs_tgt),
        .call     (call),
        .call_idx (call_idx),
        .ret      (ret),
        .halt     (halt),
        .tbl_we   (tbl_we),
        .tbl_idx  (tbl_idx),
        .tbl_addr (tbl_addr),
        .pc       (pc),
        .run      (run),
        .done     (done),
        .ras_err  (ras_err)
`ifdef FETCH_PERF_EN
        ,
        .cyc_cnt  (cyc_cnt),
        .flow_cnt (flow_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic void model_step(input stim_t s);
        int old_entry;
        if (!s.reset_n) begin
            m_pc = 0; m_st = 0; m_err = 0; m_cyc = 0; m_flow = 0;
            m_stk.delete();
            foreach (m_tbl[i]) m_tbl[i] = 0;
            return;
        end
        old_entry = m_tbl[s.call_idx];
        if (m_st != 1) begin
            if (s.start) begin
                m_st = 1; m_pc = START_PC; m_err = 0; m_cyc = 0; m_flow = 0;
                m_stk.delete();
            end
        end else if (!s.stall) begin
            m_cyc = sat16(m_cyc + 1);
            if (s.halt) begin
                m_st = 2;
            end else if (s.ret) begin
                m_flow = sat16(m_flow + 1);
                if (m_stk.size() == 0) begin
                    m_pc  = (m_pc + 1) % 1024;
                    m_err = 1;
                end else begin
                    m_pc = m_stk.pop_back();
                end
            end else if (s.call) begin
                m_flow = sat16(m_flow + 1);
                if (m_stk.size() == RAS_DEPTH) m_err = 1;
                else m_stk.push_back((m_pc + 1) % 1024);
                m_pc = old_entry;
            end else if (s.abs_take) begin
                m_flow = sat16(m_flow + 1);
                m_pc   = int'(s.abs_tgt);
            end else if (s.rel_take) begin
                m_flow = sat16(m_flow + 1);
                m_pc   = (m_pc + 1 + int'(s.rel_off)) % 1024;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
        if (s.tbl_we) m_tbl[s.tbl_idx] = int'(s.tbl_addr);
    endfunction

    function automatic stim_t nop();
        stim_t s = '0;
        s.reset_n = 1'b1;
        return s;
    endfunction

    // Apply one cycle of stimulus; expected outputs are queued after the edge.
    task automatic drive(input stim_t s);
        exp_t e;
        @(negedge clk);
        reset_n  = s.reset_n;  start    = s.start;    stall   = s.stall;
        rel_take = s.rel_take; rel_off  = s.rel_off;  abs_take = s.abs_take;
        abs_tgt  = s.abs_tgt;  call     = s.call;     call_idx = s.call_idx;
        ret      = s.ret;      halt     = s.halt;     tbl_we  = s.tbl_we;
        tbl_idx  = s.tbl_idx;  tbl_addr = s.tbl_addr;
        @(posedge clk);
        model_step(s);
        e.pc = m_pc; e.run = (m_st == 1); e.done = (m_st == 2); e.err = m_err;
        e.cyc = m_cyc; e.flow = m_flow;
        sb_q.push_back(e);
        #1;
    endtask

    // Monitor: one expected entry per clock edge, compared on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("sb_pc", int'(pc), e.pc);
            check("sb_run", int'(run), e.run);
            check("sb_done", int'(done), e.done);
            check("sb_ras_err", int'(ras_err), e.err);
`ifdef FETCH_PERF_EN
            check("sb_cyc_cnt", int'(cyc_cnt), e.cyc);
            check("sb_flow_cnt", int'(flow_cnt), e.flow);
`endif
        end
    end

    task automatic do_abs(input int tgt);
        stim_t s = nop();
        s.abs_take = 1'b1; s.abs_tgt = 10'(tgt);
        drive(s);
    endtask

    task automatic do_call(input int idx);
        stim_t s = nop();
        s.call = 1'b1; s.call_idx = 4'(idx);
        drive(s);
    endtask

    task automatic do_ret();
        stim_t s = nop();
        s.ret = 1'b1;
        drive(s);
    endtask

    task automatic do_wr(input int idx, input int val);
        stim_t s = nop();
        s.tbl_we = 1'b1; s.tbl_idx = 4'(idx); s.tbl_addr = 10'(val);
        drive(s);
    endtask

    task automatic do_start();
        stim_t s = nop();
        s.start = 1'b1;
        drive(s);
    endtask

    task automatic do_reset();
        stim_t s = nop();
        s.reset_n = 1'b0;
        drive(s);
    endtask

    initial begin
        stim_t s;
        int    exp_wrap[4];

        // Sequential fetch and wrap
        do_reset();
        do_reset();
        check("reset_pc", int'(pc), 0);
        check("reset_run", int'(run), 0);
        check("reset_done", int'(done), 0);
        check("reset_ras_err", int'(ras_err), 0);
        do_start();
        check("start_pc", int'(pc), 1021);
        check("start_run", int'(run), 1);
        exp_wrap = '{1022, 1023, 0, 1};
        for (int i = 0; i < 4; i++) begin
            drive(nop());
            check("wrap_pc", int'(pc), exp_wrap[i]);
        end
        check("wrap_done", int'(done), 0);

        // Relative skip, then relative skip losing to absolute branch
        do_abs(30);
        s = nop(); s.rel_take = 1'b1; s.rel_off = 3'd1;
        drive(s);
        check("rel_skip_pc", int'(pc), 32);
        s.abs_take = 1'b1; s.abs_tgt = 10'd15;
        drive(s);
        check("abs_over_rel_pc", int'(pc), 15);

        // Nested calls and returns
        do_wr(1, 62);
        do_wr(2, 72);
        do_abs(19);
        do_call(1);
        check("call1_pc", int'(pc), 62);
        do_call(2);
        check("call2_pc", int'(pc), 72);
        do_ret();
        check("ret1_pc", int'(pc), 63);
        do_ret();
        check("ret2_pc", int'(pc), 20);
        check("nested_ras_err", int'(ras_err), 0);

        // Stack overflow: fifth nested call still jumps
        for (int i = 0; i < 4; i++) do_call(1);
        check("full_no_err", int'(ras_err), 0);
        do_call(1);
        check("overflow_pc", int'(pc), 62);
        check("overflow_err", int'(ras_err), 1);

        // Stack underflow after reset
        do_reset();
        do_start();
        do_abs(5);
        do_ret();
        check("underflow_pc", int'(pc), 6);
        check("underflow_err", int'(ras_err), 1);

        // Stall and halt
        do_abs(40);
        s = nop(); s.stall = 1'b1; s.call = 1'b1; s.abs_take = 1'b1; s.abs_tgt = 10'd7;
        for (int i = 0; i < 3; i++) begin
            drive(s);
            check("stall_pc", int'(pc), 40);
        end
        s = nop(); s.halt = 1'b1; s.call = 1'b1; s.call_idx = 4'd1;
        drive(s);
        check("halt_pc", int'(pc), 40);
        check("halt_done", int'(done), 1);
        check("halt_run", int'(run), 0);
        do_call(1);
        check("halted_call_pc", int'(pc), 40);
        do_start();
        check("restart_pc", int'(pc), 1021);
        check("restart_err_clr", int'(ras_err), 0);

        // Reset mid-run with two stack entries
        do_wr(1, 50);
        do_wr(5, 100);
        do_call(1);
        do_call(5);
        check("pre_reset_pc", int'(pc), 100);
        do_reset();
        check("midreset_pc", int'(pc), 0);
        check("midreset_run", int'(run), 0);
`ifdef FETCH_PERF_EN
        check("midreset_cyc", int'(cyc_cnt), 0);
        check("midreset_flow", int'(flow_cnt), 0);
`endif
        do_start();
        do_ret();
        check("midreset_stack_empty", int'(ras_err), 1);
        do_call(1);
        check("midreset_tbl_zero", int'(pc), 0);

        // Randomized run
        for (int n = 0; n < 2000; n++) begin
            s          = nop();
            s.reset_n  = ($urandom_range(0, 199) != 0);
            s.start    = ($urandom_range(0, 29) == 0);
            s.stall    = ($urandom_range(0, 5) == 0);
            s.halt     = ($urandom_range(0, 59) == 0);
            s.ret      = ($urandom_range(0, 5) == 0);
            s.call     = ($urandom_range(0, 5) == 0);
            s.call_idx = 4'($urandom);
            s.abs_take = ($urandom_range(0, 5) == 0);
            s.abs_tgt  = 10'($urandom);
            s.rel_take = ($urandom_range(0, 2) == 0);
            s.rel_off  = 3'($urandom);
            s.tbl_we   = ($urandom_range(0, 3) == 0);
            s.tbl_idx  = 4'($urandom);
            s.tbl_addr = 10'($urandom);
            drive(s);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
